// File: rtl/dp_exec_unit.sv
// dp_exec_unit: single-issue ARM-style data-processing execution unit.
// Runs one op per cycle with registered result and flags. Conditional
// execution is checked against the current NZCV. An optional iterative
// shift-add multiplier takes WIDTH cycles per MUL and blocks new requests
// while it runs.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   request handshake; accept = in_valid & in_ready
//   ALUOp                 1 = data-processing op, 0 = plain address add a+b
//   cmd, S, is_mul        DP command, set-flags bit, MUL request (overrides cmd)
//   cond                  ARM condition field, evaluated at accept
//   a, b                  WIDTH-bit operands
//   result, nzcv          registered result and flags {N,Z,C,V}
//   out_valid, cond_ex    one-cycle completion pulse; cond_ex=0 when squashed
module dp_exec_unit #(
   parameter int unsigned WIDTH  = 32,
   parameter bit          MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             ALUOp,
   input  logic [3:0]       cmd,
   input  logic             S,
   input  logic             is_mul,
   input  logic [3:0]       cond,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             out_valid,
   output logic             cond_ex,
   output logic [3:0]       nzcv
);
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_MOV = 4'b1101;

   typedef enum logic {IDLE, MUL} state_t;
   state_t state, state_next;

   logic             accept, pass, mul_go, mul_last;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] prod, op_val, next_result;
   logic             op_c, op_v, wr_res, wr_nz, wr_cv;
   logic [3:0]       next_nzcv;
   logic [WIDTH-1:0] mcand, mplier, acc, acc_next;
   logic [CW-1:0]    count;
   logic             mul_s;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid & in_ready;
   assign mul_go   = accept & pass & ALUOp & is_mul & MUL_EN;
   assign mul_last = (state == MUL) && (count == CW'(WIDTH - 1));
   assign acc_next = acc + (mplier[0] ? mcand : '0);

   // Condition check against the flags currently held in the register.
   always_comb begin
      pass = 1'b0;
      case (cond)
         4'b0000: pass = nzcv[2];
         4'b0001: pass = !nzcv[2];
         4'b0010: pass = nzcv[1];
         4'b0011: pass = !nzcv[1];
         4'b0100: pass = nzcv[3];
         4'b0101: pass = !nzcv[3];
         4'b0110: pass = nzcv[0];
         4'b0111: pass = !nzcv[0];
         4'b1000: pass = nzcv[1] && !nzcv[2];
         4'b1001: pass = !nzcv[1] || nzcv[2];
         4'b1010: pass = (nzcv[3] == nzcv[0]);
         4'b1011: pass = (nzcv[3] != nzcv[0]);
         4'b1100: pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
         4'b1101: pass = nzcv[2] || (nzcv[3] != nzcv[0]);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   // Single-cycle datapath; SUB/CMP carry is the inverted borrow from a + ~b + 1.
   always_comb begin
      op_val = '0;
      op_c   = 1'b0;
      op_v   = 1'b0;
      wr_res = 1'b0;
      wr_nz  = 1'b0;
      wr_cv  = 1'b0;
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
      prod   = MUL_EN ? '0 : WIDTH'(a * b);
      if (!ALUOp) begin
         op_val = sum[WIDTH-1:0];
         wr_res = 1'b1;
      end else if (is_mul) begin
         op_val = prod;
         wr_res = 1'b1;
         wr_nz  = S;
      end else begin
         case (cmd)
            CMD_AND: begin op_val = a & b; wr_res = 1'b1; wr_nz = S; end
            CMD_EOR: begin op_val = a ^ b; wr_res = 1'b1; wr_nz = S; end
            CMD_ORR: begin op_val = a | b; wr_res = 1'b1; wr_nz = S; end
            CMD_MOV: begin op_val = b;     wr_res = 1'b1; wr_nz = S; end
            CMD_TST: begin op_val = a & b; wr_nz = 1'b1; end
            CMD_ADD: begin
               op_val = sum[WIDTH-1:0];
               op_c   = sum[WIDTH];
               op_v   = (a[WIDTH-1] == b[WIDTH-1]) && (op_val[WIDTH-1] != a[WIDTH-1]);
               wr_res = 1'b1;
               wr_nz  = S;
               wr_cv  = S;
            end
            CMD_SUB, CMD_CMP: begin
               op_val = diff[WIDTH-1:0];
               op_c   = diff[WIDTH];
               op_v   = (a[WIDTH-1] != b[WIDTH-1]) && (op_val[WIDTH-1] != a[WIDTH-1]);
               wr_res = (cmd == CMD_SUB);
               wr_nz  = S || (cmd == CMD_CMP);
               wr_cv  = S || (cmd == CMD_CMP);
            end
            default: ;
         endcase
      end
      next_result = wr_res ? op_val : result;
      next_nzcv   = {wr_nz ? {op_val[WIDTH-1], (op_val == '0)} : nzcv[3:2],
                     wr_cv ? {op_c, op_v} : nzcv[1:0]};
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (mul_go)   state_next = MUL;
         MUL:  if (mul_last) state_next = IDLE;
         default:            state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         nzcv      <= '0;
         out_valid <= 1'b0;
         cond_ex   <= 1'b0;
         mcand     <= '0;
         mplier    <= '0;
         acc       <= '0;
         count     <= '0;
         mul_s     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CW'(1);
            if (mul_last) begin
               result    <= acc_next;
               out_valid <= 1'b1;
               cond_ex   <= 1'b1;
               if (mul_s) nzcv[3:2] <= {acc_next[WIDTH-1], (acc_next == '0)};
            end
         end else if (accept) begin
            if (mul_go) begin
               mcand  <= a;
               mplier <= b;
               acc    <= '0;
               count  <= '0;
               mul_s  <= S;
            end else begin
               out_valid <= 1'b1;
               cond_ex   <= pass;
               if (pass) begin
                  result <= next_result;
                  nzcv   <= next_nzcv;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_dp_exec_unit.sv
// tb_dp_exec_unit: scoreboard bench for dp_exec_unit (WIDTH=32, MUL_EN=1).
// A driver issues directed and random ops and pushes the expected response
// from a behavioural model. A monitor pops and compares each entry on every
// out_valid, including the completion cycle.
module tb_dp_exec_unit;
   localparam int unsigned W = 32;

   localparam logic [3:0] AND_C = 4'b0000, EOR_C = 4'b0001, SUB_C = 4'b0010, ADD_C = 4'b0100;
   localparam logic [3:0] TST_C = 4'b1000, CMP_C = 4'b1010, ORR_C = 4'b1100, MOV_C = 4'b1101;
   localparam logic [3:0] AL = 4'b1110;

   logic         clk = 1'b0;
   logic         reset, in_valid, ALUOp, S, is_mul;
   logic         in_ready, out_valid, cond_ex;
   logic [3:0]   cmd, cond, nzcv;
   logic [W-1:0] a, b, result;

   dp_exec_unit #(.WIDTH(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(ALUOp), .cmd(cmd), .S(S), .is_mul(is_mul), .cond(cond),
      .a(a), .b(b), .result(result), .out_valid(out_valid),
      .cond_ex(cond_ex), .nzcv(nzcv)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [W-1:0] res;
      logic [3:0]   nzcv;
      logic         cex;
      int unsigned  cyc;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   logic [W-1:0] m_res;
   logic [3:0]   m_nzcv;
   logic [3:0]   cmds [8] = '{AND_C, EOR_C, SUB_C, ADD_C, TST_C, CMP_C, ORR_C, MOV_C};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic bit cond_ok(input logic [3:0] cd, input logic [3:0] f);
      bit n, z, c, v;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cd)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference model: full-precision integer arithmetic, then truncate.
   task automatic model_issue(input logic aluop, input logic [3:0] c, input logic s,
                              input logic mul, input logic [3:0] cd,
                              input logic [W-1:0] x, input logic [W-1:0] y,
                              input int unsigned acc_cyc);
      longint unsigned ux, uy, us;
      longint          sx, sy, ss, rs;
      logic [W-1:0]    r;
      exp_t            e;
      ux = x; uy = y;
      sx = $signed(x); sy = $signed(y);
      e.cyc = acc_cyc;
      e.cex = 1'b1;
      if (!cond_ok(cd, m_nzcv)) begin
         e.cex = 1'b0;
      end else if (!aluop) begin
         us = ux + uy; r = us[W-1:0]; m_res = r;
      end else if (mul) begin
         us = ux * uy; r = us[W-1:0]; m_res = r;
         if (s) m_nzcv[3:2] = {r[W-1], r == 0};
         e.cyc = acc_cyc + W;
      end else begin
         case (c)
            AND_C, EOR_C, ORR_C, MOV_C, TST_C: begin
               r = (c == EOR_C) ? (x ^ y) : (c == ORR_C) ? (x | y) :
                   (c == MOV_C) ? y : (x & y);
               if (c != TST_C) m_res = r;
               if (s || c == TST_C) m_nzcv[3:2] = {r[W-1], r == 0};
            end
            ADD_C: begin
               us = ux + uy; r = us[W-1:0]; ss = sx + sy; rs = $signed(r);
               m_res = r;
               if (s) m_nzcv = {r[W-1], r == 0, us[W], ss != rs};
            end
            SUB_C, CMP_C: begin
               us = ux - uy; r = us[W-1:0]; ss = sx - sy; rs = $signed(r);
               if (c == SUB_C) m_res = r;
               if (s || c == CMP_C) m_nzcv = {r[W-1], r == 0, ux >= uy, ss != rs};
            end
            default: ;
         endcase
      end
      e.res  = m_res;
      e.nzcv = m_nzcv;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic aluop, input logic [3:0] c, input logic s,
                        input logic mul, input logic [3:0] cd,
                        input logic [W-1:0] x, input logic [W-1:0] y);
      int unsigned guard = 0;
      in_valid = 1'b0;
      while (!in_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         check("ready_timeout", 0, 1);
         return;
      end
      ALUOp = aluop; cmd = c; S = s; is_mul = mul; cond = cd; a = x; b = y;
      in_valid = 1'b1;
      model_issue(aluop, c, s, mul, cd, x, y, cyc + 1);
      @(negedge clk);
   endtask

   task automatic idle(input int unsigned n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("result", result, mon_e.res);
            check("nzcv", nzcv, mon_e.nzcv);
            check("cond_ex", cond_ex, mon_e.cex);
            check("latency", cyc, mon_e.cyc);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cnt;
      logic [W-1:0] x, y;
      logic [W-1:0] ext [4] = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      reset = 1'b1; in_valid = 1'b0; ALUOp = 1'b0; cmd = '0; S = 1'b0;
      is_mul = 1'b0; cond = AL; a = '0; b = '0;
      m_res = '0; m_nzcv = '0;
      repeat (3) @(negedge clk);
      check("rst_result", result, 0);
      check("rst_nzcv", nzcv, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_cond_ex", cond_ex, 0);
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);

      // Address add ignores cmd/S and never writes flags; cond 1111 never executes.
      issue(1'b0, CMP_C, 1'b1, 1'b0, AL, 32'h100, 32'h4);
      check("addr_add_result", result, 32'h104);
      check("addr_add_nzcv", nzcv, 4'b0000);
      issue(1'b1, ADD_C, 1'b1, 1'b0, 4'b1111, 32'd5, 32'd6);
      check("nv_cond_ex", cond_ex, 0);
      check("nv_result", result, 32'h104);
      idle(1);

      issue(1'b1, SUB_C, 1'b1, 1'b0, AL, 32'd5, 32'd5);
      check("sub_eq_result", result, 0);
      check("sub_eq_nzcv", nzcv, 4'b0110);
      check("sub_eq_out_valid", out_valid, 1);
      check("sub_eq_cond_ex", cond_ex, 1);

      issue(1'b1, ADD_C, 1'b1, 1'b0, AL, 32'h7FFF_FFFF, 32'h1);
      check("add_ovf_result", result, 32'h8000_0000);
      check("add_ovf_nzcv", nzcv, 4'b1001);
      issue(1'b1, ORR_C, 1'b1, 1'b0, AL, 32'h0, 32'h0);
      check("orr_keep_cv_nzcv", nzcv, 4'b0101);

      issue(1'b1, CMP_C, 1'b0, 1'b0, AL, 32'd3, 32'd7);
      issue(1'b1, ADD_C, 1'b0, 1'b0, 4'b1011, 32'd1, 32'd1);
      check("lt_cond_ex", cond_ex, 1);
      check("lt_result", result, 32'd2);
      issue(1'b1, CMP_C, 1'b0, 1'b0, AL, 32'd3, 32'd7);
      issue(1'b1, ADD_C, 1'b0, 1'b0, 4'b1010, 32'd1, 32'd1);
      check("ge_cond_ex", cond_ex, 0);
      check("ge_result_held", result, 32'd2);
      idle(1);

      issue(1'b1, ADD_C, 1'b1, 1'b1, AL, 32'hFFFF_FFFF, 32'h2);
      in_valid = 1'b0;
      cnt = 0;
      while (!in_ready && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("mul_busy_cycles", cnt, W);
      check("mul_out_valid", out_valid, 1);
      check("mul_result", result, 32'hFFFF_FFFE);
      check("mul_n_flag", nzcv[3], 1);
      idle(1);

      for (int i = 0; i < 300; i++) begin
         logic         aluop, s, mul;
         logic [3:0]   c, cd;
         int unsigned  pat;
         mul   = ($urandom_range(0, 9) == 0);
         aluop = ($urandom_range(0, 7) != 0);
         c     = cmds[$urandom_range(0, 7)];
         s     = 1'($urandom);
         cd    = ($urandom_range(0, 2) == 0) ? AL : 4'($urandom_range(0, 15));
         pat   = $urandom_range(0, 3);
         case (pat)
            0: begin x = $urandom_range(0, 3); y = $urandom_range(0, 3); end
            1: begin x = $urandom; y = $urandom; end
            2: begin x = $urandom; y = x; end
            default: begin x = ext[$urandom_range(0, 3)]; y = ext[$urandom_range(0, 3)]; end
         endcase
         issue(aluop, c, s, mul, cd, x, y);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      // Abort a multiply with reset while in_valid is held high.
      idle(1);
      cnt = 0;
      while (sb.size() != 0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      issue(1'b1, ADD_C, 1'b1, 1'b1, AL, $urandom, $urandom);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      m_res = '0; m_nzcv = '0;
      ALUOp = 1'b1; cmd = ADD_C; S = 1'b1; is_mul = 1'b0; cond = AL;
      a = 32'd9; b = 32'd9; in_valid = 1'b1;
      @(negedge clk);
      check("abort_out_valid", out_valid, 0);
      check("abort_result", result, 0);
      check("abort_nzcv", nzcv, 0);
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0;
      check("abort_in_ready", in_ready, 1);
      idle(40);
      check("abort_in_ready_later", in_ready, 1);
      issue(1'b1, ADD_C, 1'b0, 1'b0, 4'b0000, 32'd1, 32'd2);
      check("post_reset_eq_cond_ex", cond_ex, 0);
      idle(1);

      cnt = 0;
      while (sb.size() != 0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
